// File: rtl/memory_stage_if.sv
// Data-memory port between the MEM stage (master) and the data memory (slave).
// A request is pending while req=1. All request fields hold stable until the edge where ready=1. The memory samples
// them there, and on a read it returns rdata in that same cycle.
interface memory_stage_if #(
  parameter int XLEN = 32,
  parameter int BE_W = XLEN / 8
);
  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic [BE_W-1:0] be;
  logic [XLEN-1:0] rdata;
  logic            ready;

  modport master (output req, we, addr, wdata, be, input rdata, ready);
  modport slave  (input req, we, addr, wdata, be, output rdata, ready);
endinterface

// File: rtl/memory_stage.sv
// MEM stage of the RV32 pipeline: sized loads/stores over a valid/ready data port, with stall generation
// and registered MEM/WB outputs that also feed execute-stage forwarding.
module memory_stage #(
  parameter int XLEN = 32,
  parameter int BE_W = XLEN / 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] alu_result_in,
  input  logic [XLEN-1:0] rs2_data_in,
  input  logic [4:0]      rd_in,
  input  logic            reg_write_in,
  input  logic            mem_read_in,
  input  logic            mem_write_in,
  input  logic [1:0]      mem_size,
  input  logic            mem_unsigned,
  memory_stage_if.master  dmem,
  output logic [XLEN-1:0] mem_wb_data,
  output logic [4:0]      mem_wb_rd,
  output logic            mem_wb_reg_write,
  output logic            mem_stall,
  output logic            misaligned,
  output logic [0:0]      state_dbg
);
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  logic [0:0]      state;
  logic [4:0]      rd_q;
  logic [1:0]      size_q;
  logic [1:0]      off_q;
  logic            unsigned_q;
  logic            mem_op;
  logic            aligned;
  logic [BE_W-1:0] be_n;
  logic [XLEN-1:0] wdata_n;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] load_data;

  assign mem_op    = mem_read_in | mem_write_in;
  assign state_dbg = state;

  always_comb begin
    aligned = 1'b1;
    be_n    = 4'b1111;
    wdata_n = rs2_data_in;
    case (mem_size)
      2'b00: begin
        be_n    = 4'b0001 << alu_result_in[1:0];
        wdata_n = {4{rs2_data_in[7:0]}};
      end
      2'b01: begin
        aligned = ~alu_result_in[0];
        be_n    = 4'b0011 << alu_result_in[1:0];
        wdata_n = {2{rs2_data_in[15:0]}};
      end
      default: aligned = (alu_result_in[1:0] == 2'b00);
    endcase
  end

  // The lane is chosen by the captured offset, so the data lands in bits [7:0] or [15:0] before extension.
  always_comb begin
    shifted = dmem.rdata >> {off_q, 3'b000};
    case (size_q)
      2'b00:   load_data = unsigned_q ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_data = unsigned_q ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = dmem.rdata;
    endcase
  end

  always_comb begin
    mem_stall = 1'b0;
    if (state == IDLE) mem_stall = mem_op & aligned;
    else               mem_stall = ~dmem.ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      dmem.req         <= 1'b0;
      dmem.we          <= 1'b0;
      dmem.addr        <= '0;
      dmem.wdata       <= '0;
      dmem.be          <= '0;
      rd_q             <= '0;
      size_q           <= '0;
      off_q            <= '0;
      unsigned_q       <= 1'b0;
      mem_wb_data      <= '0;
      mem_wb_rd        <= '0;
      mem_wb_reg_write <= 1'b0;
      misaligned       <= 1'b0;
    end else begin
      misaligned <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_op) begin
            mem_wb_reg_write <= 1'b0;
            if (aligned) begin
              state      <= ACCESS;
              dmem.req   <= 1'b1;
              dmem.we    <= mem_write_in;
              dmem.addr  <= {alu_result_in[XLEN-1:2], 2'b00};
              dmem.wdata <= wdata_n;
              dmem.be    <= be_n;
              rd_q       <= rd_in;
              size_q     <= mem_size;
              off_q      <= alu_result_in[1:0];
              unsigned_q <= mem_unsigned;
            end else begin
              misaligned <= 1'b1;
            end
          end else begin
            mem_wb_data      <= alu_result_in;
            mem_wb_rd        <= rd_in;
            mem_wb_reg_write <= reg_write_in && (rd_in != 5'd0);
          end
        end
        default: begin
          mem_wb_reg_write <= 1'b0;
          if (dmem.ready) begin
            state    <= IDLE;
            dmem.req <= 1'b0;
            if (!dmem.we) begin
              mem_wb_data      <= load_data;
              mem_wb_rd        <= rd_q;
              mem_wb_reg_write <= (rd_q != 5'd0);
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: the bench drives the memory side of the data port by hand.
module tb_memory_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_result_in;
  logic [31:0] rs2_data_in;
  logic [4:0]  rd_in;
  logic        reg_write_in;
  logic        mem_read_in;
  logic        mem_write_in;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic [31:0] mem_wb_data;
  logic [4:0]  mem_wb_rd;
  logic        mem_wb_reg_write;
  logic        mem_stall;
  logic        misaligned;
  logic [0:0]  state_dbg;

  int vectors = 0;
  int miscompares = 0;
  int occupancy;

  memory_stage_if dmem_bus ();

  memory_stage dut (
    .clk              (clk),
    .rst              (rst),
    .alu_result_in    (alu_result_in),
    .rs2_data_in      (rs2_data_in),
    .rd_in            (rd_in),
    .reg_write_in     (reg_write_in),
    .mem_read_in      (mem_read_in),
    .mem_write_in     (mem_write_in),
    .mem_size         (mem_size),
    .mem_unsigned     (mem_unsigned),
    .dmem             (dmem_bus.master),
    .mem_wb_data      (mem_wb_data),
    .mem_wb_rd        (mem_wb_rd),
    .mem_wb_reg_write (mem_wb_reg_write),
    .mem_stall        (mem_stall),
    .misaligned       (misaligned),
    .state_dbg        (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd, input logic rw,
                        input logic rd_en, input logic wr_en, input logic [1:0] size, input logic uns);
    alu_result_in = alu;
    rs2_data_in   = rs2;
    rd_in         = rd;
    reg_write_in  = rw;
    mem_read_in   = rd_en;
    mem_write_in  = wr_en;
    mem_size      = size;
    mem_unsigned  = uns;
  endtask

  task automatic bubble();
    set_op(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
  endtask

  // Issues a load whose memory answers on the first ACCESS cycle, then checks the write-back value.
  task automatic load_now(input string tag, input logic [31:0] addr, input logic [1:0] size, input logic uns,
                          input logic [4:0] rd, input logic [31:0] rdata, input logic [31:0] exp);
    set_op(addr, 32'h0, rd, 1'b1, 1'b1, 1'b0, size, uns);
    tick();
    dmem_bus.ready = 1'b1;
    dmem_bus.rdata = rdata;
    #1;
    chk({tag, "_stall_ready"}, 32'(mem_stall), 32'd0);
    tick();
    dmem_bus.ready = 1'b0;
    bubble();
    chk({tag, "_data"}, mem_wb_data, exp);
    chk({tag, "_we"}, 32'(mem_wb_reg_write), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    bubble();
    dmem_bus.ready = 1'b0;
    dmem_bus.rdata = 32'h0;
    tick();
    tick();
    chk("rst_req", 32'(dmem_bus.req), 32'd0);
    chk("rst_be", 32'(dmem_bus.be), 32'd0);
    chk("rst_addr", dmem_bus.addr, 32'd0);
    chk("rst_wb_data", mem_wb_data, 32'd0);
    chk("rst_wb_we", 32'(mem_wb_reg_write), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'd0);
    rst = 1'b0;

    // ALU op, with a stray ready in IDLE that must be ignored
    set_op(32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0);
    dmem_bus.ready = 1'b1;
    #1;
    chk("alu_stall", 32'(mem_stall), 32'd0);
    tick();
    dmem_bus.ready = 1'b0;
    chk("alu_data", mem_wb_data, 32'h1234);
    chk("alu_rd", 32'(mem_wb_rd), 32'd5);
    chk("alu_we", 32'(mem_wb_reg_write), 32'd1);
    chk("alu_req", 32'(dmem_bus.req), 32'd0);

    set_op(32'h55, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0);
    tick();
    chk("x0_we", 32'(mem_wb_reg_write), 32'd0);

    // LW 0x100, ready on the third request cycle
    set_op(32'h100, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
    #1;
    chk("lw_stall_issue", 32'(mem_stall), 32'd1);
    occupancy = 1;
    tick();
    chk("lw_req", 32'(dmem_bus.req), 32'd1);
    chk("lw_addr", dmem_bus.addr, 32'h100);
    chk("lw_be", 32'(dmem_bus.be), 32'hF);
    chk("lw_bubble", 32'(mem_wb_reg_write), 32'd0);
    chk("lw_stall_wait1", 32'(mem_stall), 32'd1);
    occupancy++;
    tick();
    chk("lw_stall_wait2", 32'(mem_stall), 32'd1);
    chk("lw_addr_held", dmem_bus.addr, 32'h100);
    occupancy++;
    tick();
    dmem_bus.ready = 1'b1;
    dmem_bus.rdata = 32'hDEADBEEF;
    #1;
    chk("lw_stall_ready", 32'(mem_stall), 32'd0);
    occupancy++;
    chk("lw_occupancy", 32'(occupancy), 32'd4);
    tick();
    dmem_bus.ready = 1'b0;
    bubble();
    chk("lw_data", mem_wb_data, 32'hDEADBEEF);
    chk("lw_rd", 32'(mem_wb_rd), 32'd7);
    chk("lw_we", 32'(mem_wb_reg_write), 32'd1);
    chk("lw_req_drop", 32'(dmem_bus.req), 32'd0);

    load_now("lb", 32'h103, 2'b00, 1'b0, 5'd8, 32'h80123456, 32'hFFFFFF80);
    load_now("lbu", 32'h103, 2'b00, 1'b1, 5'd8, 32'h80123456, 32'h00000080);
    load_now("lh", 32'h102, 2'b01, 1'b0, 5'd9, 32'h80010000, 32'hFFFF8001);
    load_now("lhu", 32'h100, 2'b01, 1'b1, 5'd9, 32'h1234F00D, 32'h0000F00D);

    // SH 0x102, ready immediately
    set_op(32'h102, 32'h0000ABCD, 5'd3, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
    tick();
    chk("sh_we", 32'(dmem_bus.we), 32'd1);
    chk("sh_be", 32'(dmem_bus.be), 32'hC);
    chk("sh_wdata", dmem_bus.wdata, 32'hABCDABCD);
    chk("sh_addr", dmem_bus.addr, 32'h100);
    dmem_bus.ready = 1'b1;
    tick();
    dmem_bus.ready = 1'b0;
    bubble();
    chk("sh_wb_we", 32'(mem_wb_reg_write), 32'd0);
    chk("sh_req_drop", 32'(dmem_bus.req), 32'd0);

    set_op(32'h201, 32'h1234565A, 5'd3, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
    tick();
    chk("sb_be", 32'(dmem_bus.be), 32'h2);
    chk("sb_wdata", dmem_bus.wdata, 32'h5A5A5A5A);
    chk("sb_addr", dmem_bus.addr, 32'h200);
    dmem_bus.ready = 1'b1;
    tick();
    dmem_bus.ready = 1'b0;
    bubble();

    // Misaligned LW 0x101
    set_op(32'h101, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
    #1;
    chk("mis_stall", 32'(mem_stall), 32'd0);
    tick();
    bubble();
    chk("mis_pulse", 32'(misaligned), 32'd1);
    chk("mis_req", 32'(dmem_bus.req), 32'd0);
    chk("mis_we", 32'(mem_wb_reg_write), 32'd0);
    tick();
    chk("mis_pulse_end", 32'(misaligned), 32'd0);

    // Reset in the middle of an access
    set_op(32'h200, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
    tick();
    chk("rstmid_req_before", 32'(dmem_bus.req), 32'd1);
    rst = 1'b1;
    bubble();
    tick();
    chk("rstmid_req", 32'(dmem_bus.req), 32'd0);
    chk("rstmid_stall", 32'(mem_stall), 32'd0);
    chk("rstmid_addr", dmem_bus.addr, 32'd0);
    chk("rstmid_wb_data", mem_wb_data, 32'd0);
    chk("rstmid_state", 32'(state_dbg), 32'd0);
    rst = 1'b0;
    load_now("lw_after_rst", 32'h104, 2'b10, 1'b0, 5'd10, 32'h11223344, 32'h11223344);
    chk("lw_after_rst_rd", 32'(mem_wb_rd), 32'd10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
